// File: rtl/bz_noise_sfx_pkg.sv
// Shared constants, types and the LFSR step function for the Battlezone noise effects.
// No logic of its own; no latency.
// No flow control.
package sound_pkg;

  // output_latch bit positions
  localparam int LATCH_EXPLO_LOUD = 1;
  localparam int LATCH_SHELL_LOUD = 2;
  localparam int LATCH_SHELL_EN   = 3;
  localparam int LATCH_EXPLO_EN   = 4;
  localparam int LATCH_SOUND_EN   = 5;

  // timing and decay shape defaults
  localparam int NOISE_DIV   = 256;
  localparam int SHELL_DIV   = 16;
  localparam int SHELL_SHIFT = 4;
  localparam int EXPLO_DIV   = 32;
  localparam int EXPLO_SHIFT = 5;
  localparam int LP_SHIFT    = 3;

  localparam logic [16:0] LFSR_SEED = 17'h1FFFF;

  typedef enum logic {ENV_IDLE, ENV_DECAY} env_state_t;

  // One LFSR step; an all-zero register would never leave zero, so reseed it.
  function automatic logic [16:0] lfsr_next(input logic [16:0] q);
    if (q == 17'h0) begin
      return LFSR_SEED;
    end
    return {q[15:0], q[16] ^ q[13]};
  endfunction

endpackage

// File: rtl/bz_noise_sfx_env.sv
// Triggered envelope: jumps to FF on trig, then decays by max(env>>SHIFT,1) every DIV-th tick.
// env updates the clock after trig or after the DIV-th tick; busy follows the state register.
// No backpressure; trig is a single-cycle strobe and always accepted, even mid-decay.
module noise_env
  import sound_pkg::*;
#(
  parameter int DIV   = 16,
  parameter int SHIFT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       trig,
  output logic [7:0] env,
  output logic       busy
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  env_state_t     r_state;
  logic [7:0]     r_env;
  logic [DW-1:0]  r_div;
  logic [7:0]     w_step;
  logic [7:0]     w_next;

  // Decay amount is proportional to the level, but never less than one so the tail ends.
  always_comb begin
    w_step = r_env >> SHIFT;
    if (w_step == 8'h0) begin
      w_step = 8'h1;
    end
    w_next = (r_env > w_step) ? (r_env - w_step) : 8'h0;
  end

  // Envelope FSM; a trigger takes priority over a coincident decay step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ENV_IDLE;
      r_env   <= 8'h0;
      r_div   <= '0;
    end else if (trig) begin
      r_state <= ENV_DECAY;
      r_env   <= 8'hFF;
      r_div   <= '0;
    end else if (r_state == ENV_DECAY && tick_en) begin
      if (r_div == DIV_LAST) begin
        r_div <= '0;
        r_env <= w_next;
        if (w_next == 8'h0) begin
          r_state <= ENV_IDLE;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign env  = r_env;
  assign busy = (r_state == ENV_DECAY);

endmodule

// File: rtl/bz_noise_sfx.sv
// Shell and explosion noise generator: LFSR noise gated by two decaying envelopes, explosion low-passed.
// Samples are registered and change only on the edge that consumes a 24 kHz tick.
// No backpressure; latch bits are sampled every clock and outputs free-run.
module bz_noise_sfx
  import sound_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_3MHz_en,
  input  logic       clk_24KHz_en,
  input  logic [7:0] output_latch,
  output logic       noise_bit,
  output logic [7:0] shell_out,
  output logic [7:0] explo_out
);

  localparam int NDW = $clog2(NOISE_DIV);
  localparam logic [NDW-1:0] NDIV_LAST = NDW'(NOISE_DIV - 1);

  logic [16:0]        r_lfsr;
  logic [NDW-1:0]     r_ndiv;
  logic [5:1]         r_latch;
  logic [1:0]         r_en_d;
  logic [7:0]         r_lp;
  logic [7:0]         r_shell_out;
  logic [7:0]         r_explo_out;

  logic               w_unused;
  logic               w_shell_trig;
  logic               w_explo_trig;
  logic [7:0]         w_shell_env;
  logic [7:0]         w_explo_env;
  logic               w_shell_busy;
  logic               w_explo_busy;
  logic               w_noise;
  logic [7:0]         w_shell_smp;
  logic [7:0]         w_explo_raw;
  logic signed [9:0]  w_diff;
  logic signed [9:0]  w_lp_sum;
  logic [7:0]         w_lp_next;

  assign w_unused = ^{output_latch[7:6], output_latch[0]};

  // Noise prescaler and LFSR step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
      r_ndiv <= '0;
    end else if (clk_3MHz_en) begin
      if (r_ndiv == NDIV_LAST) begin
        r_ndiv <= '0;
        r_lfsr <= lfsr_next(r_lfsr);
      end else begin
        r_ndiv <= r_ndiv + 1'b1;
      end
    end
  end

  assign w_noise   = r_lfsr[0];
  assign noise_bit = w_noise;

  // Registered latch copy plus a delayed copy of the two enables for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_latch <= '0;
      r_en_d  <= '0;
    end else begin
      r_latch <= output_latch[5:1];
      r_en_d  <= {r_latch[LATCH_EXPLO_EN], r_latch[LATCH_SHELL_EN]};
    end
  end

  assign w_shell_trig = r_latch[LATCH_SHELL_EN] & ~r_en_d[0];
  assign w_explo_trig = r_latch[LATCH_EXPLO_EN] & ~r_en_d[1];

  noise_env #(
    .DIV   (SHELL_DIV),
    .SHIFT (SHELL_SHIFT)
  ) u_shell (
    .clk     (clk),
    .rst     (rst),
    .tick_en (clk_24KHz_en),
    .trig    (w_shell_trig),
    .env     (w_shell_env),
    .busy    (w_shell_busy)
  );

  noise_env #(
    .DIV   (EXPLO_DIV),
    .SHIFT (EXPLO_SHIFT)
  ) u_explo (
    .clk     (clk),
    .rst     (rst),
    .tick_en (clk_24KHz_en),
    .trig    (w_explo_trig),
    .env     (w_explo_env),
    .busy    (w_explo_busy)
  );

  // Noise gating with loud/soft scaling, then the explosion one-pole low-pass with clamp.
  always_comb begin
    w_shell_smp = 8'h0;
    w_explo_raw = 8'h0;
    if (w_noise) begin
      w_shell_smp = r_latch[LATCH_SHELL_LOUD] ? w_shell_env : {1'b0, w_shell_env[7:1]};
      w_explo_raw = r_latch[LATCH_EXPLO_LOUD] ? w_explo_env : {1'b0, w_explo_env[7:1]};
    end
    w_diff   = $signed({2'b00, w_explo_raw}) - $signed({2'b00, r_lp});
    w_lp_sum = $signed({2'b00, r_lp}) + (w_diff >>> LP_SHIFT);
    if (w_lp_sum < 10'sd0) begin
      w_lp_next = 8'h0;
    end else if (w_lp_sum > 10'sd255) begin
      w_lp_next = 8'hFF;
    end else begin
      w_lp_next = w_lp_sum[7:0];
    end
  end

  // Filter state and output samples advance on the sample tick; sound_en only mutes outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lp        <= 8'h0;
      r_shell_out <= 8'h0;
      r_explo_out <= 8'h0;
    end else if (clk_24KHz_en) begin
      r_lp        <= w_lp_next;
      r_shell_out <= r_latch[LATCH_SOUND_EN] ? w_shell_smp : 8'h0;
      r_explo_out <= r_latch[LATCH_SOUND_EN] ? w_lp_next   : 8'h0;
    end
  end

  assign shell_out = r_shell_out;
  assign explo_out = r_explo_out;

endmodule

// File: tb/tb_bz_noise_sfx.sv
module tb_bz_noise_sfx;

  logic       clk;
  logic       rst;
  logic       clk_3MHz_en;
  logic       clk_24KHz_en;
  logic [7:0] output_latch;
  logic       noise_bit;
  logic [7:0] shell_out;
  logic [7:0] explo_out;

  int checks;
  int failures;

  bz_noise_sfx dut (
    .clk          (clk),
    .rst          (rst),
    .clk_3MHz_en  (clk_3MHz_en),
    .clk_24KHz_en (clk_24KHz_en),
    .output_latch (output_latch),
    .noise_bit    (noise_bit),
    .shell_out    (shell_out),
    .explo_out    (explo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one 24 kHz enable pulse; returns at the negedge after the consuming posedge
  task automatic tick();
    @(negedge clk) clk_24KHz_en = 1'b1;
    @(negedge clk) clk_24KHz_en = 1'b0;
  endtask

  function automatic logic [16:0] ref_lfsr(input logic [16:0] q);
    logic fb;
    if (q == 17'h0) return 17'h1FFFF;
    fb = q[16] ^ q[13];
    return (q << 1) | {16'h0, fb};
  endfunction

  initial begin
    logic [16:0] m;
    logic [7:0]  ps, pe;
    int          retrig;
    bit          done;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    clk_3MHz_en = 1'b0;
    clk_24KHz_en = 1'b0;
    output_latch = 8'h00;

    // reset state
    cyc(2);
    chk("rst_noise", noise_bit, 1);
    chk("rst_shell", shell_out, 0);
    chk("rst_explo", explo_out, 0);
    chk("rst_lfsr", dut.r_lfsr, 17'h1FFFF);
    chk("rst_env", {dut.w_shell_env, dut.w_explo_env}, 0);
    rst = 1'b0;
    cyc(3);
    chk("idle_busy", {dut.w_shell_busy, dut.w_explo_busy}, 0);

    // muted explosion (loud) + shell, filter runs while muted
    output_latch = 8'h1A;
    cyc(2);
    chk("mute_trig_env", {dut.w_shell_env, dut.w_explo_env}, 16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("mute_out", {shell_out, explo_out}, 0);
    end
    chk("mute_shell_decay", dut.w_shell_env, 8'hF0);
    chk("mute_explo_env", dut.w_explo_env, 8'hFF);
    output_latch = 8'h3A;
    cyc(1);
    chk("unmute_no_tick", {shell_out, explo_out}, 0);
    tick();
    chk("unmute_explo_lp", explo_out, 8'hE1);
    chk("unmute_shell", shell_out, 8'h78);

    // asynchronous reset while both envelopes are busy
    output_latch = 8'h38;
    #2 rst = 1'b1;
    #1;
    chk("arst_out", {shell_out, explo_out}, 0);
    chk("arst_lfsr", dut.r_lfsr, 17'h1FFFF);
    chk("arst_env", {dut.w_shell_env, dut.w_explo_env}, 0);
    chk("arst_busy", {dut.w_shell_busy, dut.w_explo_busy}, 0);
    @(negedge clk) rst = 1'b0;
    cyc(1);
    chk("rel_no_trig_yet", {dut.w_shell_env, dut.w_explo_env}, 0);
    cyc(1);
    chk("rel_trig_env", {dut.w_shell_env, dut.w_explo_env}, 16'hFFFF);

    // soft shell and soft explosion with noise_bit held at 1
    tick();
    chk("soft_shell_t1", shell_out, 8'h7F);
    chk("soft_explo_t1", explo_out, 8'h0F);
    repeat (15) tick();
    chk("shell_env_16", dut.w_shell_env, 8'hF0);
    tick();
    chk("soft_shell_t17", shell_out, 8'h78);

    // LFSR: first step after 256 enables, then follow the reference
    clk_3MHz_en = 1'b1;
    cyc(255);
    chk("lfsr_hold_255", dut.r_lfsr, 17'h1FFFF);
    cyc(1);
    chk("lfsr_step1", dut.r_lfsr, 17'h1FFFE);
    chk("noise_step1", noise_bit, 0);
    clk_3MHz_en = 1'b0;
    tick();
    chk("shell_noise0", shell_out, 0);
    m = 17'h1FFFE;
    clk_3MHz_en = 1'b1;
    for (int i = 0; i < 19; i++) begin
      cyc(256);
      m = ref_lfsr(m);
      chk("lfsr_seq", dut.r_lfsr, m);
      chk("lfsr_noise", noise_bit, m[0]);
      chk("lfsr_nonzero", (dut.r_lfsr != 17'h0), 1);
    end
    clk_3MHz_en = 1'b0;

    // held enables decay to zero with no retrigger
    retrig = 0;
    done = 1'b0;
    ps = dut.w_shell_env;
    pe = dut.w_explo_env;
    for (int i = 0; i < 8000 && !done; i++) begin
      tick();
      if (dut.w_shell_env > ps) retrig++;
      if (dut.w_explo_env > pe) retrig++;
      ps = dut.w_shell_env;
      pe = dut.w_explo_env;
      if (!dut.w_shell_busy && !dut.w_explo_busy) done = 1'b1;
    end
    chk("decay_done_in_budget", done, 1);
    chk("decay_no_retrig", retrig, 0);
    chk("decay_env_zero", {dut.w_shell_env, dut.w_explo_env}, 0);
    repeat (40) tick();
    chk("held_stays_idle", {dut.w_shell_busy, dut.w_explo_busy, dut.w_shell_env, dut.w_explo_env}, 0);
    chk("held_shell_out", shell_out, 0);

    // explosion retrigger mid-decay
    output_latch = 8'h28;
    cyc(3);
    output_latch = 8'h38;
    cyc(2);
    chk("explo_trig", dut.w_explo_env, 8'hFF);
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      tick();
      if (dut.w_explo_env <= 8'h40) done = 1'b1;
    end
    chk("explo_reach_40", done, 1);
    chk("explo_busy_40", dut.w_explo_busy, 1);
    output_latch = 8'h28;
    cyc(3);
    output_latch = 8'h38;
    cyc(2);
    chk("explo_retrig", dut.w_explo_env, 8'hFF);
    repeat (31) tick();
    chk("explo_pre_coinc", dut.w_explo_env, 8'hFF);
    output_latch = 8'h28;
    cyc(3);
    output_latch = 8'h38;
    @(negedge clk) clk_24KHz_en = 1'b1;
    @(negedge clk) clk_24KHz_en = 1'b0;
    chk("coinc_trig_wins", dut.w_explo_env, 8'hFF);
    repeat (31) tick();
    chk("coinc_div_cleared", dut.w_explo_env, 8'hFF);
    tick();
    chk("explo_first_step", dut.w_explo_env, 8'hF8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
